// File: rtl/par_gen_chk_pkg.sv
// Shared parity definitions for the UART transmit/receive datapath.
package par_gen_chk_pkg;

  // Parity mode selectors
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  // Default character and frame widths (frame = data bits + parity bit)
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_FRAME_W = DEF_DATA_W + 1;

endpackage

// File: rtl/par_gen_chk_if.sv
// Bus bundle for the parity generator/checker.
// The master side drives characters and frames; the slave side is the checker.
interface par_gen_chk_if
  import par_gen_chk_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = 16
);
  logic [DATA_W-1:0] data_in;
  logic              par_bit;
  logic              chk_valid;
  logic [DATA_W:0]   chk_frame;
  logic              chk_done;
  logic              chk_err;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_cnt;
  logic              clr_err;

  modport master (
    output data_in, chk_valid, chk_frame, clr_err,
    input  par_bit, chk_done, chk_err, err_sticky, err_cnt
  );

  modport slave (
    input  data_in, chk_valid, chk_frame, clr_err,
    output par_bit, chk_done, chk_err, err_sticky, err_cnt
  );
endinterface

// File: rtl/par_gen_chk_par_calc.sv
// Combinational parity: XOR-reduce of the data, inverted in odd mode.
module par_calc
  import par_gen_chk_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_DATA_W,
  parameter bit          ODD_PARITY = PAR_EVEN
) (
  input  logic [WIDTH-1:0] data,
  output logic             par
);

  // Parity bit that makes the total count of ones even (or odd)
  always_comb begin
    par = (^data) ^ ODD_PARITY;
  end

endmodule

// File: rtl/par_gen_chk.sv
// Parity generator plus registered frame checker with sticky error flag
// and saturating error counter.
module par_gen_chk
  import par_gen_chk_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter bit          ODD_PARITY = PAR_EVEN,
  parameter int unsigned CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  par_gen_chk_if.slave  bus
);

  logic             exp_par;
  logic             mism;
  logic             hit;
  logic             done_q;
  logic             err_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  par_calc #(
    .WIDTH      (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) u_gen (
    .data (bus.data_in),
    .par  (bus.par_bit)
  );

  par_calc #(
    .WIDTH      (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) u_chk (
    .data (bus.chk_frame[DATA_W:1]),
    .par  (exp_par)
  );

  // Frame mismatch and the qualified error event
  always_comb begin
    mism = (exp_par != bus.chk_frame[0]);
    hit  = bus.chk_valid & mism;
  end

  // One-cycle done pulse per valid frame; error result held between frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= bus.chk_valid;
      if (bus.chk_valid) begin
        err_q <= mism;
      end
    end
  end

  // Status: a mismatch in the clear cycle wins, restarting the count at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (hit) begin
      sticky_q <= 1'b1;
      if (bus.clr_err) begin
        cnt_q <= CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (bus.clr_err) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end
  end

  assign bus.chk_done   = done_q;
  assign bus.chk_err    = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_cnt    = cnt_q;

endmodule

// File: tb/tb_par_gen_chk.sv
// Scoreboard bench: an even-parity/16-bit-count DUT and an odd-parity/2-bit-count
// DUT receive identical stimulus; a behavioural model predicts each result.
module tb_par_gen_chk;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  par_gen_chk_if #(.DATA_W(DW), .CNT_W(16)) bus0 ();
  par_gen_chk_if #(.DATA_W(DW), .CNT_W(2))  bus1 ();

  par_gen_chk #(.DATA_W(DW), .ODD_PARITY(0), .CNT_W(16)) u_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  par_gen_chk #(.DATA_W(DW), .ODD_PARITY(1), .CNT_W(2)) u_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard queues of expected chk_err, one per DUT
  bit q0[$];
  bit q1[$];
  bit          m_sticky[2];
  int unsigned m_cnt[2];
  int unsigned m_max[2];

  function automatic bit parity(input logic [DW-1:0] d, input bit odd);
    return bit'(($countones(d) % 2) == 1) ^ odd;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [7:0] d, input logic v, input logic [8:0] f, input logic c);
    bus0.data_in = d;  bus1.data_in = d;
    bus0.chk_valid = v; bus1.chk_valid = v;
    bus0.chk_frame = f; bus1.chk_frame = f;
    bus0.clr_err = c;  bus1.clr_err = c;
  endtask

  // Drive one cycle of stimulus and predict the outcome of the next edge
  task automatic step(input logic [7:0] d, input logic v, input logic [8:0] f, input logic c);
    bit m;
    @(negedge clk);
    #1;
    set_in(d, v, f, c);
    for (int k = 0; k < 2; k++) begin
      m = (parity(f[8:1], k == 1) != f[0]);
      if (c) begin
        m_sticky[k] = 1'b0;
        m_cnt[k] = 0;
      end
      if (v && m) begin
        m_sticky[k] = 1'b1;
        if (m_cnt[k] < m_max[k]) m_cnt[k]++;
      end
      if (v) begin
        if (k == 0) q0.push_back(m);
        else        q1.push_back(m);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done0"}, bus0.chk_done, 0);
    chk({tag, "_err0"},  bus0.chk_err, 0);
    chk({tag, "_stk0"},  bus0.err_sticky, 0);
    chk({tag, "_cnt0"},  bus0.err_cnt, 0);
    chk({tag, "_done1"}, bus1.chk_done, 0);
    chk({tag, "_cnt1"},  bus1.err_cnt, 0);
  endtask

  // Monitor: pop an expectation whenever a DUT reports a result
  always @(negedge clk) begin
    bit e;
    if (rst_n) begin
      chk("par_bit0", bus0.par_bit, parity(bus0.data_in, 1'b0));
      chk("par_bit1", bus1.par_bit, parity(bus1.data_in, 1'b1));
      chk("done0", bus0.chk_done, q0.size() != 0);
      chk("done1", bus1.chk_done, q1.size() != 0);
      if (bus0.chk_done && q0.size() != 0) begin
        e = q0.pop_front();
        chk("err0", bus0.chk_err, e);
      end
      if (bus1.chk_done && q1.size() != 0) begin
        e = q1.pop_front();
        chk("err1", bus1.chk_err, e);
      end
      chk("sticky0", bus0.err_sticky, m_sticky[0]);
      chk("cnt0",    bus0.err_cnt, m_cnt[0]);
      chk("sticky1", bus1.err_sticky, m_sticky[1]);
      chk("cnt1",    bus1.err_cnt, m_cnt[1]);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] gen_d   [5] = '{8'h00, 8'h01, 8'hFF, 8'hA5, 8'h07};
  bit         gen_ev  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  bit         gen_od  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    m_max[0] = 65535;
    m_max[1] = 3;
    m_sticky[0] = 1'b0; m_sticky[1] = 1'b0;
    m_cnt[0] = 0;       m_cnt[1] = 0;
    set_in(8'h07, 1'b0, 9'h000, 1'b0);
    #2;
    check_zero("reset");
    chk("rst_par_bit", bus0.par_bit, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Generator truth table
    for (int i = 0; i < 5; i++) begin
      step(gen_d[i], 1'b0, 9'h000, 1'b0);
      #1;
      chk("gen_even", bus0.par_bit, gen_ev[i]);
      chk("gen_odd",  bus1.par_bit, gen_od[i]);
    end

    // Two good frames back to back, then a bad one, then idle
    step(8'h00, 1'b1, 9'h14A, 1'b0);
    step(8'h00, 1'b1, 9'h003, 1'b0);
    step(8'h00, 1'b1, 9'h002, 1'b0);
    @(posedge clk); #2;
    chk("bad_err",  bus0.chk_err, 1);
    chk("bad_stk",  bus0.err_sticky, 1);
    chk("bad_cnt",  bus0.err_cnt, 1);
    step(8'h00, 1'b0, 9'h000, 1'b0);
    @(posedge clk); #2;
    chk("idle_done", bus0.chk_done, 0);
    chk("idle_stk",  bus0.err_sticky, 1);

    // Clear alone, then clear together with a bad frame
    step(8'h00, 1'b0, 9'h000, 1'b1);
    @(posedge clk); #2;
    chk("clr_stk", bus0.err_sticky, 0);
    chk("clr_cnt", bus0.err_cnt, 0);
    step(8'h00, 1'b1, 9'h002, 1'b1);
    @(posedge clk); #2;
    chk("clrhit_stk", bus0.err_sticky, 1);
    chk("clrhit_cnt", bus0.err_cnt, 1);

    // Saturation: 9'h14A is good for even mode, bad for odd mode
    step(8'h00, 1'b0, 9'h000, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 9'h14A, 1'b0);
    step(8'h00, 1'b0, 9'h000, 1'b0);
    @(posedge clk); #2;
    chk("sat_cnt1", bus1.err_cnt, 3);
    chk("sat_cnt0", bus0.err_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), ($urandom % 4) != 0, 9'($urandom), ($urandom % 16) == 0);
    end

    // Async reset while a result is showing and the count is non-zero
    step(8'h00, 1'b1, 9'h002, 1'b0);
    @(posedge clk); #2;
    chk("pre_rst_done", bus0.chk_done, 1);
    rst_n = 1'b0;
    set_in(8'h00, 1'b0, 9'h000, 1'b0);
    #1;
    check_zero("async_rst");
    q0.delete();
    q1.delete();
    m_sticky[0] = 1'b0; m_sticky[1] = 1'b0;
    m_cnt[0] = 0;       m_cnt[1] = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 9'h000, 1'b0);
    step(8'h3C, 1'b1, 9'h079, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 9'h000, 1'b0);
    @(negedge clk); #2;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
